fetch_queue: RTL

- Instruction queue directly downstream of the second fetch stage; decouples fetch from decode.
- Captures valid/PC/data/exception bundles each cycle and presents them in order to decode through a valid/ready handshake.
- Generates the stall back into both fetch stages early enough to absorb in-flight fetches.
- Fences further fetches after a faulting entry until the pipeline is flushed.

---
 rtl/fetch_queue_pkg.sv | 32 +++
 rtl/fetch_queue_fifo_ram.sv | 27 ++
 rtl/fetch_queue.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and default sizing for the fetch queue and its storage.
`ifndef FETCH_QUEUE_DEPTH
`define FETCH_QUEUE_DEPTH 8
`endif
`ifndef FETCH_QUEUE_SKID
`define FETCH_QUEUE_SKID 2
`endif

package fetch_queue_pkg;

  localparam int PC_WIDTH     = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int EXCEPT_WIDTH = 5;

  typedef logic [PC_WIDTH-1:0]     program_counter_t;
  typedef logic [DATA_WIDTH-1:0]   fetch_data_t;
  // {valid, code}; valid is the MSB
  typedef logic [EXCEPT_WIDTH-1:0] except_t;

  typedef struct packed {
    program_counter_t pc;
    fetch_data_t      data;
    except_t          except;
  } fetch_queue_entry_t;

  localparam int ENTRY_WIDTH = $bits(fetch_queue_entry_t);

  function automatic logic except_valid(input except_t e);
    return e[EXCEPT_WIDTH-1];
  endfunction

endpackage

// File: rtl/fetch_queue_fifo_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port.
// No reset on the array; validity is tracked by the queue's count.
module fifo_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 69,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the accepted fetch into the tail slot
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch stage 2 and decode. Generates an early
// stall with SKID slots of headroom and fences fetch after a faulting entry.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = `FETCH_QUEUE_DEPTH,
  parameter int SKID  = `FETCH_QUEUE_SKID
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  program_counter_t i_pc,
  input  fetch_data_t      i_data,
  input  except_t          i_except,
  output logic             o_stall,
  output logic             o_valid,
  output program_counter_t o_pc,
  output fetch_data_t      o_data,
  output except_t          o_except,
  input  logic             i_ready,
  output logic             o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_C = CW'(DEPTH - SKID);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fence_q, fence_d;

  logic               push;
  logic               pop;
  logic               fetch_live;
  fetch_queue_entry_t wr_entry;
  fetch_queue_entry_t rd_entry;

  assign o_valid = (count_q != '0);
  assign o_stall = (count_q >= STALL_C);

  // Handshake decode: fetches behind a fence or in a flush cycle never count
  always_comb begin
    fetch_live = i_valid & ~i_flush & ~fence_q;
    pop        = o_valid & i_ready;
    push       = fetch_live & ((count_q < DEPTH_C) | pop);
    o_overflow = fetch_live & (count_q == DEPTH_C) & ~pop;
  end

  // Pointer, count and fence next-state; flush overrides any push/pop
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    fence_d = fence_q;
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      fence_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      fence_d = fence_q | (push & except_valid(i_except));
    end
  end

  // Queue control state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      fence_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      fence_q <= fence_d;
    end
  end

  assign wr_entry.pc     = i_pc;
  assign wr_entry.data   = i_data;
  assign wr_entry.except = i_except;

  fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_WIDTH),
    .AW    (PW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wptr_q),
    .i_wdata (wr_entry),
    .i_raddr (rptr_q),
    .o_rdata (rd_entry)
  );

  // Head fields read as zero whenever the queue is empty
  always_comb begin
    o_pc     = '0;
    o_data   = '0;
    o_except = '0;
    if (o_valid) begin
      o_pc     = rd_entry.pc;
      o_data   = rd_entry.data;
      o_except = rd_entry.except;
    end
  end

endmodule
